// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds the FSM state encoding, byte-lane constants and the data/RAM address widths
// used by mem_access_unit and byte_lane_merge.
package mem_access_unit_pkg;

    localparam int unsigned DataWidth    = 32;
    localparam int unsigned RamAddrWidth = 10;

    // FSM state encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Little-endian byte lanes selected by address bits [1:0]
    localparam logic [1:0] Lane0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] Lane1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] Lane2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] Lane3 = 2'd3;  // bits [31:24]

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane helper.
// Ports:
//   word_i    - source word (RAM read data)
//   lane_i    - selected byte lane (address bits [1:0])
//   byte_i    - byte to insert for a byte store
//   extract_o - selected lane of word_i, zero-extended
//   merged_o  - word_i with the selected lane replaced by byte_i
module byte_lane_merge
    import mem_access_unit_pkg::*;
(
    input  logic [DataWidth-1:0] word_i,
    input  logic [1:0]           lane_i,
    input  logic [7:0]           byte_i,
    output logic [DataWidth-1:0] extract_o,
    output logic [DataWidth-1:0] merged_o
);

    always_comb begin
        extract_o = '0;
        merged_o  = word_i;
        unique case (lane_i)
            Lane0: begin
                extract_o[7:0] = word_i[7:0];
                merged_o[7:0]  = byte_i;
            end
            Lane1: begin
                extract_o[7:0] = word_i[15:8];
                merged_o[15:8] = byte_i;
            end
            Lane2: begin
                extract_o[7:0]  = word_i[23:16];
                merged_o[23:16] = byte_i;
            end
            Lane3: begin
                extract_o[7:0]  = word_i[31:24];
                merged_o[31:24] = byte_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit sitting between the decode stage and a word-wide RAM.
// Word loads/stores take one RAM access; byte loads extract a lane; byte stores
// perform a read-modify-write (RD then WR).
// Ports:
//   Clk, Reset_n           - clock, asynchronous active-low reset
//   Start                  - begin an access (sampled only in IDLE)
//   Mem_WrEn, Byte_en      - store/load and byte/word select, captured on Start
//   ALU_MEM_Addr           - byte address, captured on Start
//   MEM_DataIn             - store data, captured on Start
//   MEM_out                - last load result
//   Busy, Done             - access in flight / one-cycle completion pulse
//   Ram_Req, Ram_We        - RAM request and write strobe
//   Ram_Addr, Ram_Wdata    - RAM word index and write data
//   Ram_Rdata, Ram_Ack     - RAM read data (valid with Ack) and acknowledge
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic                    Mem_WrEn,
    input  logic                    Byte_en,
    input  logic [DataWidth-1:0]    ALU_MEM_Addr,
    input  logic [DataWidth-1:0]    MEM_DataIn,
    output logic [DataWidth-1:0]    MEM_out,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Ram_Req,
    output logic                    Ram_We,
    output logic [RamAddrWidth-1:0] Ram_Addr,
    output logic [DataWidth-1:0]    Ram_Wdata,
    input  logic [DataWidth-1:0]    Ram_Rdata,
    input  logic                    Ram_Ack
);

    logic [1:0]           state_q, state_d;
    logic                 we_q, we_d;
    logic                 byte_q, byte_d;
    logic [11:0]          addr_q, addr_d;   // word index [11:2] + lane [1:0]
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] mem_out_q, mem_out_d;

    logic [DataWidth-1:0] lane_extract;
    logic [DataWidth-1:0] lane_merged;

    // Address bits above the RAM window are not needed.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALU_MEM_Addr[DataWidth-1:12];

    byte_lane_merge u_byte_lane_merge (
        .word_i    (Ram_Rdata),
        .lane_i    (addr_q[1:0]),
        .byte_i    (wdata_q[7:0]),
        .extract_o (lane_extract),
        .merged_o  (lane_merged)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_out_d = mem_out_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    we_d    = Mem_WrEn;
                    byte_d  = Byte_en;
                    addr_d  = ALU_MEM_Addr[11:0];
                    wdata_d = MEM_DataIn;
                    // Only a word store skips the read phase.
                    state_d = (Mem_WrEn && !Byte_en) ? StWr : StRd;
                end
            end
            StRd: begin
                if (Ram_Ack) begin
                    if (we_q) begin
                        // Byte store: the merged word becomes the write data for WR.
                        wdata_d = lane_merged;
                        state_d = StWr;
                    end else begin
                        mem_out_d = byte_q ? lane_extract : Ram_Rdata;
                        state_d   = StDone;
                    end
                end
            end
            StWr: begin
                if (Ram_Ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_out_q <= mem_out_d;
        end
    end

    assign Ram_Req   = (state_q == StRd) || (state_q == StWr);
    assign Ram_We    = (state_q == StWr);
    assign Busy      = Ram_Req;
    assign Done      = (state_q == StDone);
    assign Ram_Addr  = addr_q[11:2];
    assign Ram_Wdata = wdata_q;
    assign MEM_out   = mem_out_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a RAM responder with programmable Ack delay,
// and a word-array reference model of loads, word stores and byte read-modify-writes.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Mem_WrEn = 1'b0;
    logic        Byte_en = 1'b0;
    logic [31:0] ALU_MEM_Addr = '0;
    logic [31:0] MEM_DataIn = '0;
    logic [31:0] MEM_out;
    logic        Busy;
    logic        Done;
    logic        Ram_Req;
    logic        Ram_We;
    logic [9:0]  Ram_Addr;
    logic [31:0] Ram_Wdata;
    logic [31:0] Ram_Rdata;
    logic        Ram_Ack;

    logic        resp_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    assign Ram_Ack   = resp_ack | man_ack;
    assign Ram_Rdata = resp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int n_rd = 0;
    int n_wr = 0;
    bit pending = 1'b0;
    logic [9:0]  p_addr;
    logic        p_we;
    logic [31:0] p_wdata;

    logic [31:0] ram [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_mem_out = '0;

    mem_access_unit u_dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Mem_WrEn     (Mem_WrEn),
        .Byte_en      (Byte_en),
        .ALU_MEM_Addr (ALU_MEM_Addr),
        .MEM_DataIn   (MEM_DataIn),
        .MEM_out      (MEM_out),
        .Busy         (Busy),
        .Done         (Done),
        .Ram_Req      (Ram_Req),
        .Ram_We       (Ram_We),
        .Ram_Addr     (Ram_Addr),
        .Ram_Wdata    (Ram_Wdata),
        .Ram_Rdata    (Ram_Rdata),
        .Ram_Ack      (Ram_Ack)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // RAM responder: acks after ack_delay waiting cycles, commits writes at the Ack edge,
    // and checks the request stays asserted and stable while stalled.
    always @(negedge Clk) begin
        resp_ack = 1'b0;
        if (!Reset_n) begin
            wait_cnt = 0;
            pending  = 1'b0;
        end else if (Ram_Req) begin
            if (pending) begin
                check_eq("stable_addr", {22'd0, Ram_Addr}, {22'd0, p_addr});
                check_eq("stable_we", {31'd0, Ram_We}, {31'd0, p_we});
                check_eq("stable_wdata", Ram_Wdata, p_wdata);
            end
            if (wait_cnt >= ack_delay) begin
                resp_ack = 1'b1;
                wait_cnt = 0;
                pending  = 1'b0;
                if (Ram_We) begin
                    ram[Ram_Addr] = Ram_Wdata;
                    n_wr++;
                end else begin
                    resp_rdata = ram[Ram_Addr];
                    n_rd++;
                end
            end else begin
                wait_cnt++;
                pending = 1'b1;
                p_addr  = Ram_Addr;
                p_we    = Ram_We;
                p_wdata = Ram_Wdata;
            end
        end else begin
            if (pending) check_eq("req_held", {31'd0, Ram_Req}, 32'd1);
            pending  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic do_op(input logic we, input logic byt, input logic [31:0] addr,
                         input logic [31:0] data, input int dly,
                         input bit poke_busy, input bit poke_done);
        logic [9:0]  idx;
        logic [1:0]  lane;
        int          sh;
        logic [31:0] mask;
        int          exp_rd, exp_wr, exp_cyc, rd0, wr0, cyc, done_cyc;
        idx  = addr[11:2];
        lane = addr[1:0];
        sh   = 8 * int'(lane);
        mask = 32'hFF << sh;
        exp_rd = 0;
        exp_wr = 0;
        if (!we) begin
            exp_rd = 1;
            exp_mem_out = byt ? ((ref_mem[idx] >> sh) & 32'hFF) : ref_mem[idx];
        end else if (!byt) begin
            exp_wr = 1;
            ref_mem[idx] = data;
        end else begin
            exp_rd = 1;
            exp_wr = 1;
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((data & 32'hFF) << sh);
        end
        exp_cyc = (exp_rd + exp_wr) * (dly + 1) + 1;

        ack_delay = dly;
        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge Clk);
        Start = 1'b1;
        Mem_WrEn = we;
        Byte_en = byt;
        ALU_MEM_Addr = addr;
        MEM_DataIn = data;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        // Scramble inputs to show they were captured.
        Mem_WrEn = 1'($urandom);
        Byte_en = 1'($urandom);
        ALU_MEM_Addr = $urandom;
        MEM_DataIn = $urandom;
        cyc = 0;
        done_cyc = -1;
        while (cyc < 200 && done_cyc < 0) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) begin
                check_eq("busy_after_start", {31'd0, Busy}, 32'd1);
                check_eq("req_after_start", {31'd0, Ram_Req}, 32'd1);
                check_eq("ram_addr", {22'd0, Ram_Addr}, {22'd0, idx});
            end
            if (Done) begin
                done_cyc = cyc;
                check_eq("busy_in_done", {31'd0, Busy}, 32'd0);
            end else if (poke_busy && cyc == 2) begin
                Start = 1'b1;
                Mem_WrEn = 1'b1;
                Byte_en = 1'b0;
                ALU_MEM_Addr = 32'h0000_0FFC;
                MEM_DataIn = 32'hBAD0_BAD0;
                @(posedge Clk);
                #1;
                Start = 1'b0;
            end
        end
        check_eq("done_cycle", done_cyc, exp_cyc);
        if (poke_done && done_cyc > 0) begin
            Start = 1'b1;
            Mem_WrEn = 1'b1;
            Byte_en = 1'b0;
            ALU_MEM_Addr = 32'h0000_0FFC;
            MEM_DataIn = 32'h5A5A_5A5A;
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        check_eq("done_pulse", {31'd0, Done}, 32'd0);
        check_eq("idle_after_done", {30'd0, Ram_Req, Busy}, 32'd0);
        check_eq("mem_out", MEM_out, exp_mem_out);
        check_eq("ram_word", ram[idx], ref_mem[idx]);
        check_eq("n_reads", n_rd - rd0, exp_rd);
        check_eq("n_writes", n_wr - wr0, exp_wr);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, MEM_out | Ram_Wdata | {22'd0, Ram_Addr}, 32'd0);
        check_eq(tag, {28'd0, Busy, Done, Ram_Req, Ram_We}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[5] = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;
        ram[3] = 32'h1122_3344;
        ref_mem[3] = 32'h1122_3344;

        #12;
        check_all_zero("reset_outputs");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed scenarios
        do_op(1'b0, 1'b0, 32'h14, 32'h0, 0, 1'b0, 1'b0);
        check_eq("word_load_val", MEM_out, 32'hDEAD_BEEF);
        do_op(1'b0, 1'b1, 32'h16, 32'h0, 0, 1'b0, 1'b0);
        check_eq("byte_load_lane2", MEM_out, 32'h0000_00AD);
        do_op(1'b1, 1'b1, 32'h0D, 32'h0000_00AB, 0, 1'b0, 1'b0);
        check_eq("rmw_result", ram[3], 32'h1122_AB44);
        check_eq("rmw_mem_out_kept", MEM_out, 32'h0000_00AD);
        do_op(1'b1, 1'b0, 32'h20, 32'h1234_5678, 4, 1'b1, 1'b1);
        check_eq("stall_store", ram[8], 32'h1234_5678);

        // Randomized traffic over a small window so words get reused
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            int d;
            a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            d = $urandom_range(0, 3);
            do_op(1'($urandom), 1'($urandom), a, $urandom, d,
                  (d >= 2) && 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a read, then a stray Ack after release
        ack_delay = 1000;
        @(negedge Clk);
        Start = 1'b1;
        Mem_WrEn = 1'b0;
        Byte_en = 1'b1;
        ALU_MEM_Addr = 32'h0000_0015;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        check_eq("rst_rd_req", {31'd0, Ram_Req}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset_outputs");
        exp_mem_out = '0;
        repeat (2) @(negedge Clk);
        #2;
        Reset_n = 1'b1;
        @(negedge Clk);
        man_ack = 1'b1;
        @(negedge Clk);
        man_ack = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            check_all_zero("post_reset_idle");
        end

        do_op(1'b0, 1'b0, 32'h0000_0014, 32'h0, 1, 1'b0, 1'b0);
        check_eq("untouched_word", ram[1023], ref_mem[1023]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
